// File: rtl/uart_arb_pkg.sv
// Shared types and parameter defaults for the UART TX arbiter slice.
package uart_arb_pkg;

  localparam int NUM_REQ_DEFAULT        = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_XFER = 1'b1;

endpackage : uart_arb_pkg

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: scans from last_owner+1 (mod NUM_REQ)
// and returns the first pending requester as a one-hot vector.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic [NUM_REQ-1:0] winner_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(last_owner_i) + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule : uart_rr_picker

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets one requester at a time stream a message into
// the UART TX FIFO. Define UART_TX_ARB_TIMEOUT_EN to add the idle-grant watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_wren,
  input  logic                 tx_fifo_full,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   winner;
  logic [IDX_W-1:0]     win_idx;
  logic                 xfer;
  logic                 fire;
  logic                 owner_last;
  logic                 timeout_hit;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i        (req_valid),
    .last_owner_i (last_owner_q),
    .winner_o     (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = IDX_W'(i);
    end
  end

  // Datapath is purely combinational off the registered grant: zero-latency
  // forwarding, and reset clears every output asynchronously through grant_q.
  assign xfer      = (state_q == ST_XFER);
  assign busy      = xfer;
  assign grant     = grant_q;
  assign req_ready = xfer ? (grant_q & {NUM_REQ{~tx_fifo_full}}) : '0;
  assign fire      = |(req_valid & req_ready);
  assign tx_wren   = fire;

  always_comb begin
    tx_data    = '0;
    owner_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_last = req_last[i];
        if (fire) tx_data = req_data[i*8 +: 8];
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_err_q;

  // Counts stalled-by-requester cycles only; FIFO backpressure freezes it.
  always_comb begin
    wdog_d      = wdog_q;
    timeout_hit = 1'b0;
    if (!xfer || fire) begin
      wdog_d = '0;
    end else if (!tx_fifo_full) begin
      if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
        wdog_d      = '0;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_hit;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if (state_q == ST_IDLE) begin
      if (|req_valid) begin
        state_d = ST_XFER;
        grant_d = winner;
        owner_d = win_idx;
      end
    end else if ((fire && owner_last) || timeout_hit) begin
      state_d      = ST_IDLE;
      grant_d      = '0;
      last_owner_d = owner_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; covers both builds of
// UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic                 sys_clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_wren;
  logic                 tx_fifo_full;
  logic                 busy;
  logic                 timeout_err;

  int         checks = 0;
  int         passed = 0;
  logic [7:0] wr_log[$];
  logic [7:0] exp_log[$];

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .grant        (grant),
    .tx_data      (tx_data),
    .tx_wren      (tx_wren),
    .tx_fifo_full (tx_fifo_full),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Every byte the FIFO would accept, in order.
  always @(posedge sys_clk) begin
    if (reset_n && tx_wren) wr_log.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_out(input string tag, input logic [NUM_REQ-1:0] e_grant,
                            input logic [NUM_REQ-1:0] e_ready, input logic e_wren,
                            input logic [7:0] e_data, input logic e_busy);
    check({tag, "_grant"}, 32'(grant), 32'(e_grant));
    check({tag, "_ready"}, 32'(req_ready), 32'(e_ready));
    check({tag, "_wren"}, 32'(tx_wren), 32'(e_wren));
    check({tag, "_data"}, 32'(tx_data), 32'(e_data));
    check({tag, "_busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_byte(input int r, input logic [7:0] d, input logic last);
    for (int b = 0; b < 8; b++) req_data[r*8 + b] = d[b];
    req_last[r] = last;
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    tx_fifo_full = 1'b0;
    repeat (2) step();
    expect_out("reset", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    check("reset_terr", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    step();

    // Round-robin from reset: requester 0 first, then 2.
    set_byte(0, 8'h10, 1'b1);
    set_byte(2, 8'h30, 1'b1);
    req_valid = 4'b0101;
    #1;
    expect_out("rr_idle", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    step();
    expect_out("rr_first", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
    step();
    expect_out("rr_release", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    step();
    expect_out("rr_second", 4'b0100, 4'b0100, 1'b1, 8'h30, 1'b1);
    step();
    req_valid = '0;
    #1;
    expect_out("rr_done", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

    // Three-byte message from requester 1 while requester 2 waits.
    set_byte(1, 8'h41, 1'b0);
    set_byte(2, 8'h99, 1'b1);
    req_valid = 4'b0110;
    step();
    expect_out("msg_b0", 4'b0010, 4'b0010, 1'b1, 8'h41, 1'b1);
    step();
    set_byte(1, 8'h42, 1'b0);
    #1;
    expect_out("msg_b1", 4'b0010, 4'b0010, 1'b1, 8'h42, 1'b1);
    step();
    set_byte(1, 8'h43, 1'b1);
    #1;
    expect_out("msg_b2", 4'b0010, 4'b0010, 1'b1, 8'h43, 1'b1);
    step();
    req_valid = 4'b0100;
    #1;
    expect_out("msg_end", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    step();
    expect_out("msg_next", 4'b0100, 4'b0100, 1'b1, 8'h99, 1'b1);
    step();
    req_valid = '0;
    #1;
    expect_out("msg_done", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

    // FIFO full for five cycles in the middle of a message.
    set_byte(3, 8'h51, 1'b0);
    req_valid = 4'b1000;
    step();
    expect_out("full_b0", 4'b1000, 4'b1000, 1'b1, 8'h51, 1'b1);
    step();
    set_byte(3, 8'h52, 1'b0);
    tx_fifo_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("full_hold%0d", i), 4'b1000, 4'b0000, 1'b0, 8'h00, 1'b1);
      if (i < 4) step();
    end
    step();
    tx_fifo_full = 1'b0;
    #1;
    expect_out("full_resume", 4'b1000, 4'b1000, 1'b1, 8'h52, 1'b1);
    step();
    set_byte(3, 8'h53, 1'b1);
    #1;
    expect_out("full_last", 4'b1000, 4'b1000, 1'b1, 8'h53, 1'b1);
    step();
    req_valid = '0;
    #1;
    expect_out("full_done", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

    // Owner 0 stalls mid-message while requester 1 waits.
    set_byte(0, 8'h61, 1'b0);
    set_byte(1, 8'h71, 1'b1);
    req_valid = 4'b0011;
    step();
    expect_out("gap_b0", 4'b0001, 4'b0001, 1'b1, 8'h61, 1'b1);
    step();
    req_valid = 4'b0010;
    #1;
    expect_out("gap_c1", 4'b0001, 4'b0001, 1'b0, 8'h00, 1'b1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int i = 2; i <= 16; i++) begin
      step();
      check($sformatf("wd_hold%0d_grant", i), 32'(grant), 32'h1);
      check($sformatf("wd_hold%0d_terr", i), 32'(timeout_err), 32'd0);
    end
    step();
    expect_out("wd_revoke", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    check("wd_pulse", 32'(timeout_err), 32'd1);
    step();
    expect_out("wd_next", 4'b0010, 4'b0010, 1'b1, 8'h71, 1'b1);
    check("wd_pulse_end", 32'(timeout_err), 32'd0);
`else
    for (int i = 2; i <= 24; i++) begin
      step();
      check($sformatf("gap_hold%0d_grant", i), 32'(grant), 32'h1);
      check($sformatf("gap_hold%0d_terr", i), 32'(timeout_err), 32'd0);
    end
    step();
    set_byte(0, 8'h62, 1'b1);
    req_valid = 4'b0011;
    #1;
    expect_out("gap_last", 4'b0001, 4'b0001, 1'b1, 8'h62, 1'b1);
    step();
    expect_out("gap_release", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    step();
    expect_out("gap_next", 4'b0010, 4'b0010, 1'b1, 8'h71, 1'b1);
`endif
    step();
    req_valid = '0;
    #1;
    expect_out("gap_done", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

    // Reset asserted between clock edges while requester 2 has a byte on the bus.
    set_byte(2, 8'h81, 1'b0);
    req_valid = 4'b0100;
    step();
    expect_out("rst_b0", 4'b0100, 4'b0100, 1'b1, 8'h81, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("rst_async", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    check("rst_async_terr", 32'(timeout_err), 32'd0);
    set_byte(0, 8'h91, 1'b1);
    req_valid = 4'b0101;
    step();
    step();
    expect_out("rst_hold", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    step();
    expect_out("rst_first", 4'b0001, 4'b0001, 1'b1, 8'h91, 1'b1);
    step();
    req_valid = '0;
    #1;
    expect_out("rst_done", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    step();

    exp_log = '{8'h10, 8'h30, 8'h41, 8'h42, 8'h43, 8'h99, 8'h51, 8'h52, 8'h53, 8'h61};
`ifndef UART_TX_ARB_TIMEOUT_EN
    exp_log.push_back(8'h62);
`endif
    exp_log.push_back(8'h71);
    exp_log.push_back(8'h91);
    check("log_len", 32'(wr_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < wr_log.size()) check($sformatf("log_%0d", i), 32'(wr_log[i]), 32'(exp_log[i]));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the idle-grant watchdog limit in sys_clk cycles.
REQ-003 SHALL have port sys_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port req_last  input  NUM_REQ  per-requester last byte of a message.
REQ-007 SHALL have port req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester byte accepted.
REQ-009 SHALL have port grant  output  NUM_REQ  one-hot current owner, or all zeros.
REQ-010 SHALL have port tx_data  output  8  byte to the UART TX FIFO write port.
REQ-011 SHALL have port tx_wren  output  1  TX FIFO write strobe, one byte per cycle.
REQ-012 SHALL have port tx_fifo_full  input  1  TX FIFO full flag.
REQ-013 SHALL have port busy  output  1  high while a message is owned.
REQ-014 SHALL have port timeout_err  output  1  single-cycle pulse when the watchdog revokes a grant.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and XFER.
REQ-016 In IDLE with any req_valid high, SHALL pick a winner round-robin, starting at index last_owner+1 modulo NUM_REQ, register a one-hot grant and move to XFER; IDLE SHALL last exactly one cycle when requests are pending.
REQ-017 In XFER, req_ready[g] SHALL equal ~tx_fifo_full for the owner g; all other req_ready bits SHALL be 0.
REQ-018 A transfer occurs when req_valid[g] and req_ready[g] are both high; on that cycle, combinationally, tx_wren SHALL be 1 and tx_data SHALL equal req_data of g (zero latency).
REQ-019 tx_wren SHALL never be 1 while tx_fifo_full is high or outside XFER.
REQ-020 A transfer with req_last[g] high SHALL end the message: next state IDLE, grant cleared, last_owner set to g.
REQ-021 The grant SHALL be held across gaps where req_valid[g] is low mid-message; other requesters SHALL wait.
REQ-022 A requester SHALL hold req_data and req_last stable while req_valid is high and req_ready is low; the arbiter does not buffer.
REQ-023 busy SHALL equal (state == XFER).
REQ-024 A single-byte message (req_last high on the first byte) SHALL release the grant after one transfer.

Reset
REQ-025 Asserting reset_n low SHALL force: state IDLE, grant 0, req_ready 0, tx_wren 0, tx_data 0, busy 0, timeout_err 0, watchdog 0, last_owner NUM_REQ-1 (requester 0 wins first).
REQ-026 Reset asserted mid-message SHALL abort the message immediately with no further writes; on release, arbitration restarts as from REQ-025.

Configuration
REQ-027 With UART_TX_ARB_TIMEOUT_EN defined, in XFER a counter SHALL increment on each cycle with no transfer while tx_fifo_full is low, clear on each transfer, and hold while tx_fifo_full is high.
REQ-028 With UART_TX_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES: grant SHALL be revoked, last_owner set to g, state set to IDLE, and timeout_err pulsed for one cycle.
REQ-029 Without UART_TX_ARB_TIMEOUT_EN, the counter SHALL be absent, timeout_err SHALL be tied 0, and the grant SHALL be held indefinitely until req_last.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the FSM state typedef, the NUM_REQ default, and the TIMEOUT_CYCLES default.
REQ-031 Round-robin selection SHALL be a combinational sub-module, uart_rr_picker (inputs: request vector, last_owner; output: one-hot winner).

Verification
REQ-032 Reset, then req_valid=4'b0101 held -> grant 4'b0001 first; after its last byte, grant 4'b0100.
REQ-033 Requester 1 sends bytes 0x41, 0x42, 0x43 (last on 0x43) while requester 2 requests -> tx_data 0x41, 0x42, 0x43 in order; no requester 2 byte is interleaved.
REQ-034 tx_fifo_full high for 5 cycles mid-message -> req_ready 0 and tx_wren 0 for those 5 cycles; no byte lost or duplicated.
REQ-035 With macro defined and TIMEOUT_CYCLES=16, owner drops req_valid without last -> on the 16th idle cycle, grant 0 and timeout_err high for exactly 1 cycle; next requester granted.
REQ-036 Reset_n pulsed low mid-message -> all outputs go to REQ-025 values asynchronously; requester 0 wins next.
